mio_bus: RTL and testbench
==========================

MIO_BUS -- requirements
Module: mio_bus

Interface
REQ-001 Parameter RAM_WAIT, default 2, SHALL set wait-state cycles for RAM accesses (legal 0..15).
REQ-002 Parameter RAM_AW, default 10, SHALL set RAM word-address width.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 CPU_MIO  input  1  bus request from CPU.
REQ-006 mem_w  input  1  1 = write, 0 = read; sampled with request.
REQ-007 Addr_out  input  32  byte address from CPU.
REQ-008 Data_out  input  32  write data from CPU.
REQ-009 MIO_ready  output  1  one-cycle completion pulse to CPU.
REQ-010 Data_in  output  32  read data to CPU; valid when MIO_ready=1.
REQ-011 ram_addr  output  RAM_AW  word address to synchronous RAM.
REQ-012 ram_we  output  1  RAM write strobe; ram_din  output  32  RAM write data; ram_dout  input  32  RAM read data (1-cycle latency).
REQ-013 sw  input  16  switch inputs; led  output  16  LED register.

Function
REQ-014 Address map SHALL be: RAM 0x0000_0000-(4*2^RAM_AW-1), word index Addr_out[RAM_AW+1:2]; LED 0xF000_0000 R/W (bits 15:0); SW 0xF000_0004 read-only; CNT 0xF000_0008 R/W; all other addresses unmapped.
REQ-015 FSM states SHALL be IDLE, WAIT, RESP.
REQ-016 In IDLE with CPU_MIO=1 the block SHALL latch Addr_out, mem_w, Data_out and go to WAIT if RAM and RAM_WAIT>0, else to RESP.
REQ-017 WAIT SHALL count RAM_WAIT cycles (counter loaded RAM_WAIT-1, decremented to 0) then go to RESP; ram_addr SHALL be driven from the latched address throughout WAIT and RESP.
REQ-018 Latency from request-accept edge to MIO_ready SHALL be 1 cycle for peripheral/unmapped, RAM_WAIT+1 cycles for RAM.
REQ-019 In RESP MIO_ready SHALL be 1 for exactly one cycle, then return to IDLE; no new request SHALL be accepted in the RESP cycle (back-to-back requests spaced >=2 cycles).
REQ-020 Writes SHALL commit only in the RESP cycle: ram_we=1 for RAM writes; LED/CNT registers update on the RESP edge.
REQ-021 Read data SHALL be: RAM -> ram_dout; LED -> {16'b0,led}; SW -> {16'b0,sw} sampled in RESP; CNT -> counter value in RESP; unmapped -> 0. Data_in SHALL be 0 whenever MIO_ready=0.
REQ-022 Unmapped accesses SHALL complete normally; writes to unmapped or SW addresses SHALL be ignored.
REQ-023 CNT SHALL increment by 1 every cycle, wrapping 0xFFFF_FFFF -> 0; a CNT write in the same cycle SHALL win over increment.
REQ-024 CPU_MIO deasserting after acceptance SHALL NOT abort the transaction; changes on Addr_out/Data_out after acceptance SHALL be ignored.

Reset
REQ-025 On reset: state IDLE, MIO_ready=0, Data_in=0, ram_we=0, led=0, CNT=0, wait counter=0.
REQ-026 Reset during WAIT or RESP SHALL abort the transaction with no write committed and no MIO_ready pulse.

Structure
REQ-027 Address-map constants (base addresses, region decode masks) and state encoding SHALL live in shared package mio_pkg.
REQ-028 A sub-module mio_addr_dec (combinational region decode: RAM/LED/SW/CNT/unmapped) SHALL be instantiated; FSM, counter and registers stay in mio_bus.

Verification
REQ-029 RAM write 0x0000_0010 data 0xDEADBEEF, RAM_WAIT=2 -> ram_we pulse at cycle 3 after accept with ram_addr=4; MIO_ready same cycle.
REQ-030 RAM read of same address -> MIO_ready at cycle 3, Data_in=0xDEADBEEF for one cycle, 0 otherwise.
REQ-031 Write 0x0000_A5A5 to 0xF000_0000 -> led=0xA5A5 after RESP edge; read back returns 0x0000_A5A5 with 1-cycle latency.
REQ-032 Write 0xFFFF_FFFE to CNT, read 3 cycles later -> value wraps through 0 (expect small value consistent with cycle count).
REQ-033 Assert reset during WAIT of a RAM write -> no ram_we, no MIO_ready; next request after reset completes normally.
REQ-034 Read 0x8000_0000 (unmapped) -> MIO_ready after 1 cycle, Data_in=0; CPU_MIO held high continuously -> second request accepted only after RESP.

Source files
------------

// File: rtl/mio_pkg.sv
// Shared address map, region and FSM encodings for the memory/IO bus bridge.
package mio_pkg;

  localparam logic [31:0] RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] LED_ADDR = 32'hF000_0000;
  localparam logic [31:0] SW_ADDR  = 32'hF000_0004;
  localparam logic [31:0] CNT_ADDR = 32'hF000_0008;

  typedef enum logic [2:0] {
    REG_RAM  = 3'd0,
    REG_LED  = 3'd1,
    REG_SW   = 3'd2,
    REG_CNT  = 3'd3,
    REG_NONE = 3'd4
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Mask keeping the address bits above the RAM window of 4*2^aw bytes.
  function automatic logic [31:0] ram_mask(input int aw);
    return ~((32'd4 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/mio_addr_dec.sv
// Combinational region decode of a CPU byte address into RAM/LED/SW/CNT/unmapped.
module mio_addr_dec
  import mio_pkg::*;
#(
  parameter int RAM_AW = 10
) (
  input  logic [31:0] addr,
  output region_t     region
);

  // Peripheral registers match on the full byte address; anything else is unmapped.
  always_comb begin
    region = REG_NONE;
    if ((addr & ram_mask(RAM_AW)) == RAM_BASE) region = REG_RAM;
    else if (addr == LED_ADDR)                 region = REG_LED;
    else if (addr == SW_ADDR)                  region = REG_SW;
    else if (addr == CNT_ADDR)                 region = REG_CNT;
  end

endmodule

// File: rtl/mio_bus.sv
// CPU-to-memory/IO bridge: one outstanding request, RAM wait states, LED/SW/CNT registers.
module mio_bus
  import mio_pkg::*;
#(
  parameter int RAM_WAIT = 2,
  parameter int RAM_AW   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       Addr_out,
  input  logic [31:0]       Data_out,
  output logic              MIO_ready,
  output logic [31:0]       Data_in,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw,
  output logic [15:0]       led,
  output state_t            dbg_state
);

  // Handshake: a request is accepted on the rising edge where state is IDLE and
  // CPU_MIO=1; MIO_ready is then a single-cycle completion pulse, after which the
  // bridge idles one cycle before it can accept again. CPU_MIO is not a hold signal.
  localparam logic [3:0] WAIT_LOAD = (RAM_WAIT > 0) ? 4'(RAM_WAIT - 1) : 4'd0;

  state_t             state_q, state_d;
  region_t            req_region, region_q;
  logic [3:0]         wait_cnt_q;
  logic [RAM_AW-1:0]  idx_q;
  logic [31:0]        data_q;
  logic               we_q;
  logic [15:0]        led_q;
  logic [31:0]        cnt_q;
  logic               accept;

  mio_addr_dec #(.RAM_AW(RAM_AW)) u_dec (
    .addr   (Addr_out),
    .region (req_region)
  );

  assign accept = (state_q == ST_IDLE) && CPU_MIO;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (CPU_MIO)
                 state_d = ((req_region == REG_RAM) && (RAM_WAIT > 0)) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (wait_cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= 4'd0;
      idx_q      <= '0;
      data_q     <= 32'd0;
      we_q       <= 1'b0;
      region_q   <= REG_NONE;
      led_q      <= 16'd0;
      cnt_q      <= 32'd0;
    end else begin
      if (accept) begin
        wait_cnt_q <= WAIT_LOAD;
        idx_q      <= Addr_out[RAM_AW+1:2];
        data_q     <= Data_out;
        we_q       <= mem_w;
        region_q   <= req_region;
      end else if ((state_q == ST_WAIT) && (wait_cnt_q != 4'd0)) begin
        wait_cnt_q <= wait_cnt_q - 4'd1;
      end
      if ((state_q == ST_RESP) && we_q && (region_q == REG_LED)) led_q <= data_q[15:0];
      // A committed CNT write takes priority over the free-running increment.
      if ((state_q == ST_RESP) && we_q && (region_q == REG_CNT)) cnt_q <= data_q;
      else                                                       cnt_q <= cnt_q + 32'd1;
    end
  end

  always_comb begin
    MIO_ready = (state_q == ST_RESP) && !reset;
    ram_we    = MIO_ready && we_q && (region_q == REG_RAM);
    Data_in   = 32'd0;
    if (MIO_ready && !we_q) begin
      case (region_q)
        REG_RAM: Data_in = ram_dout;
        REG_LED: Data_in = {16'd0, led_q};
        REG_SW:  Data_in = {16'd0, sw};
        REG_CNT: Data_in = cnt_q;
        default: Data_in = 32'd0;
      endcase
    end
    // In IDLE the RAM sees the live address so a zero-wait read has data in RESP.
    ram_addr  = (state_q == ST_IDLE) ? Addr_out[RAM_AW+1:2] : idx_q;
    ram_din   = data_q;
    led       = led_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_mio_bus.sv
// Directed plus randomized bench for mio_bus with a synchronous RAM fixture.
module tb_mio_bus;
  import mio_pkg::*;

  localparam int RAM_WAIT  = 2;
  localparam int RAM_AW    = 10;
  localparam int RAM_WORDS = 1 << RAM_AW;
  localparam int R_RAM = 0, R_LED = 1, R_SW = 2, R_CNT = 3, R_NONE = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              CPU_MIO, mem_w;
  logic [31:0]       Addr_out, Data_out;
  logic              MIO_ready;
  logic [31:0]       Data_in;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_din, ram_dout;
  logic [15:0]       sw, led;
  state_t            dbg_state;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  logic [31:0] base_val;
  int unsigned base_cyc;
  logic [15:0] ref_led;
  logic [31:0] ref_mem [RAM_WORDS];
  logic [31:0] mem [RAM_WORDS];
  logic [31:0] exp_q [$];

  mio_bus #(.RAM_WAIT(RAM_WAIT), .RAM_AW(RAM_AW)) dut (
    .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
    .Addr_out(Addr_out), .Data_out(Data_out), .MIO_ready(MIO_ready),
    .Data_in(Data_in), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_din(ram_din), .ram_dout(ram_dout), .sw(sw), .led(led),
    .dbg_state(dbg_state)
  );

  // Clock / reset block and RAM fixture
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  function automatic int tb_region(input logic [31:0] a);
    if (a < 32'(RAM_WORDS * 4)) return R_RAM;
    if (a == 32'hF000_0000)     return R_LED;
    if (a == 32'hF000_0004)     return R_SW;
    if (a == 32'hF000_0008)     return R_CNT;
    return R_NONE;
  endfunction

  function automatic logic [31:0] cnt_now();
    return base_val + 32'(cyc - base_cyc);
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    CPU_MIO = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, MIO_ready}, 32'd0);
    check("rst_data", Data_in, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_led", {16'd0, led}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    base_val = 32'd0;
    base_cyc = cyc;
    ref_led = 16'd0;
  endtask

  // Driver: called at a negedge with the bridge idle; returns at the MIO_ready negedge.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rdata, output int lat);
    CPU_MIO = 1'b1; mem_w = we; Addr_out = addr; Data_out = data;
    @(posedge clk);
    #1;
    CPU_MIO = 1'b0; mem_w = ~we; Addr_out = $urandom; Data_out = $urandom; sw = 16'($urandom);
    lat = 0;
    rdata = 32'd0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (MIO_ready) begin
        lat = k;
        rdata = Data_in;
        break;
      end
      check("data_zero_wait", Data_in, 32'd0);
    end
  endtask

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] data);
    int          rk, lat, exp_lat;
    int unsigned idx;
    logic [31:0] rd, exp_rd;
    rk = tb_region(addr);
    idx = (addr >> 2) % RAM_WORDS;
    exp_lat = (rk == R_RAM) ? RAM_WAIT + 1 : 1;
    do_req(we, addr, data, rd, lat);
    check("latency", 32'(lat), 32'(exp_lat));
    case (rk)
      R_RAM:   exp_rd = ref_mem[idx];
      R_LED:   exp_rd = {16'd0, ref_led};
      R_SW:    exp_rd = {16'd0, sw};
      R_CNT:   exp_rd = cnt_now();
      default: exp_rd = 32'd0;
    endcase
    if (!we) begin
      exp_q.push_back(exp_rd);
      check("read_data", rd, exp_q.pop_front());
    end
    check("ram_we", {31'd0, ram_we}, {31'd0, (we && rk == R_RAM)});
    if (we && rk == R_RAM) begin
      check("ram_addr", 32'(ram_addr), idx);
      check("ram_din", ram_din, data);
    end
    @(posedge clk);
    @(negedge clk);
    if (we) begin
      if (rk == R_RAM) ref_mem[idx] = data;
      if (rk == R_LED) ref_led = data[15:0];
      if (rk == R_CNT) begin base_val = data; base_cyc = cyc; end
    end
    check("led", {16'd0, led}, {16'd0, ref_led});
    check("ready_pulse_end", {31'd0, MIO_ready}, 32'd0);
    check("data_zero_after", Data_in, 32'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    int          rk;
    reset = 1'b1; CPU_MIO = 1'b0; mem_w = 1'b0;
    Addr_out = 32'd0; Data_out = 32'd0; sw = 16'h1234;
    for (int i = 0; i < RAM_WORDS; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    apply_reset();

    run_txn(1'b0, 32'hF000_0008, 32'd0);
    run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    run_txn(1'b0, 32'h0000_0010, 32'd0);
    run_txn(1'b1, 32'hF000_0000, 32'h0000_A5A5);
    run_txn(1'b0, 32'hF000_0000, 32'd0);
    run_txn(1'b1, 32'hF000_0008, 32'hFFFF_FFFE);
    @(negedge clk);
    run_txn(1'b0, 32'hF000_0008, 32'd0);
    run_txn(1'b0, 32'hF000_0004, 32'd0);
    run_txn(1'b1, 32'h0000_0FFC, 32'h0BAD_F00D);
    run_txn(1'b0, 32'h0000_0FFC, 32'd0);
    run_txn(1'b0, 32'h0000_1000, 32'd0);
    run_txn(1'b0, 32'hF000_000C, 32'd0);
    run_txn(1'b0, 32'hF000_0001, 32'd0);
    run_txn(1'b1, 32'hF000_0004, 32'hFFFF_FFFF);
    run_txn(1'b1, 32'h8000_0000, 32'h5555_5555);
    run_txn(1'b0, 32'hF000_0000, 32'd0);

    // Reset while a RAM write sits in WAIT
    CPU_MIO = 1'b1; mem_w = 1'b1; Addr_out = 32'h40; Data_out = 32'h1234_5678;
    @(posedge clk); #1 CPU_MIO = 1'b0;
    @(negedge clk);
    check("wait_state", 32'(dbg_state), 32'(ST_WAIT));
    reset = 1'b1; #1;
    check("abort_wait_ready", {31'd0, MIO_ready}, 32'd0);
    check("abort_wait_we", {31'd0, ram_we}, 32'd0);
    apply_reset();
    run_txn(1'b0, 32'h0000_0040, 32'd0);

    // Reset landing on the RESP cycle of a RAM write
    CPU_MIO = 1'b1; mem_w = 1'b1; Addr_out = 32'h44; Data_out = 32'hCAFE_0001;
    @(posedge clk); #1 CPU_MIO = 1'b0;
    repeat (RAM_WAIT + 1) @(negedge clk);
    check("resp_state", 32'(dbg_state), 32'(ST_RESP));
    reset = 1'b1; #1;
    check("abort_resp_ready", {31'd0, MIO_ready}, 32'd0);
    check("abort_resp_we", {31'd0, ram_we}, 32'd0);
    apply_reset();
    run_txn(1'b0, 32'h0000_0044, 32'd0);
    run_txn(1'b1, 32'h0000_0044, 32'hCAFE_0002);
    run_txn(1'b0, 32'h0000_0044, 32'd0);

    // CPU_MIO held high across two unmapped reads: ready must pulse 1,0,1,0
    CPU_MIO = 1'b1; mem_w = 1'b0; Addr_out = 32'h8000_0000;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("held_ready", {31'd0, MIO_ready}, {31'd0, (k == 1 || k == 3)});
      check("held_data", Data_in, 32'd0);
      if (k == 3) CPU_MIO = 1'b0;
    end

    for (int n = 0; n < 40; n++) begin
      rk = $urandom_range(0, 4);
      case (rk)
        0:       a = 32'($urandom_range(0, RAM_WORDS - 1)) * 4 + 32'($urandom_range(0, 3));
        1:       a = 32'hF000_0000;
        2:       a = 32'hF000_0004;
        3:       a = 32'hF000_0008;
        default: a = 32'h1000_0000 + 32'($urandom_range(0, 1000));
      endcase
      d = $urandom;
      sw = 16'($urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      run_txn(1'($urandom_range(0, 1)), a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
